// File: rtl/mac_stream.sv
// mac_stream: pipelined signed multiply-accumulate engine.
// Each frame is TAPS accepted a/b pairs; one dot-product result and an overflow flag come out per frame.
// Valid/ready handshakes on both sides; a held result stalls the whole pipeline.
// Optional feature macro: MAC_STREAM_SAT_EN clamps the accumulator on signed overflow instead of wrapping.
module mac_stream #(
   parameter int W     = 8,
   parameter int TAPS  = 16,
   parameter int GUARD = 4,
   localparam int ACC_W = 2*W + GUARD
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_ovf
);

   localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;

   logic             en;
   logic             accept;
   logic             isLast;
   logic [2*W-1:0]   mulFull;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2*W-1:0]   prod_q, prod_d;
   logic             pValid_q, pValid_d;
   logic             pLast_q, pLast_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovfAcc_q, ovfAcc_d;
   logic [ACC_W-1:0] outData_q, outData_d;
   logic             outOvf_q, outOvf_d;
   logic             outValid_q, outValid_d;

   logic [ACC_W-1:0] prodExt;
   logic [ACC_W-1:0] sumRaw;
   logic [ACC_W-1:0] sumFinal;
   logic             addOvf;

   // A result that is valid but not taken freezes every stage, so nothing is lost or overwritten.
   assign en       = !(outValid_q && !out_ready);
   assign accept   = in_valid && en;
   assign in_ready = en;
   assign isLast   = (cnt_q == CNT_W'(TAPS - 1));

   // Operands are widened to the full product width first so the multiply is exact.
   assign mulFull = (2*W)'($signed(a)) * (2*W)'($signed(b));

   // The product is sign-extended into the guard bits before it joins the accumulator.
   assign prodExt = ACC_W'($signed(prod_q));
   assign sumRaw  = acc_q + prodExt;
   assign addOvf  = (acc_q[ACC_W-1] == prodExt[ACC_W-1]) && (sumRaw[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef MAC_STREAM_SAT_EN
   // On overflow clamp toward the sign of the operands; later adds continue from the clamped value.
   always_comb begin
      sumFinal = sumRaw;
      if (addOvf) begin
         sumFinal = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end
`else
   assign sumFinal = sumRaw;
`endif

   // Next-state for the product stage, the frame counter, the accumulator and the output register.
   always_comb begin
      cnt_d      = cnt_q;
      prod_d     = prod_q;
      pValid_d   = pValid_q;
      pLast_d    = pLast_q;
      acc_d      = acc_q;
      ovfAcc_d   = ovfAcc_q;
      outData_d  = outData_q;
      outOvf_d   = outOvf_q;
      outValid_d = outValid_q;
      if (en) begin
         pValid_d = accept;
         pLast_d  = isLast;
         if (accept) begin
            prod_d = mulFull;
            cnt_d  = isLast ? '0 : cnt_q + 1'b1;
         end
         if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
         end
         if (pValid_q) begin
            if (pLast_q) begin
               outData_d  = sumFinal;
               outOvf_d   = ovfAcc_q | addOvf;
               outValid_d = 1'b1;
               acc_d      = '0;
               ovfAcc_d   = 1'b0;
            end else begin
               acc_d    = sumFinal;
               ovfAcc_d = ovfAcc_q | addOvf;
            end
         end
      end
   end

   // State registers; clear discards any partial frame and any held result.
   always_ff @(posedge clk) begin
      if (clear) begin
         cnt_q      <= '0;
         prod_q     <= '0;
         pValid_q   <= 1'b0;
         pLast_q    <= 1'b0;
         acc_q      <= '0;
         ovfAcc_q   <= 1'b0;
         outData_q  <= '0;
         outOvf_q   <= 1'b0;
         outValid_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         prod_q     <= prod_d;
         pValid_q   <= pValid_d;
         pLast_q    <= pLast_d;
         acc_q      <= acc_d;
         ovfAcc_q   <= ovfAcc_d;
         outData_q  <= outData_d;
         outOvf_q   <= outOvf_d;
         outValid_q <= outValid_d;
      end
   end

   assign out_valid = outValid_q;
   assign out_data  = outData_q;
   assign out_ovf   = outOvf_q;

endmodule

// File: tb/tb_mac_stream.sv
// tb_mac_stream: scoreboard bench for mac_stream.
// dut0: W=8 TAPS=4 GUARD=4, dut1: W=8 TAPS=4 GUARD=0 (overflow), dut2: W=8 TAPS=1 GUARD=4.
// Expected results are pushed when a frame is issued; a forked monitor pops them on each output handshake.
module tb_mac_stream;

   logic clk = 1'b0;
   logic clear;
   logic inValid  [3];
   logic [7:0] aIn [3];
   logic [7:0] bIn [3];
   logic inReady  [3];
   logic outValid [3];
   logic outReady [3];
   logic outOvf   [3];
   logic [19:0] outData0;
   logic [15:0] outData1;
   logic [19:0] outData2;
   logic signed [31:0] outDataS [3];

   int expData [3][$];
   bit expOvf  [3][$];

   int compared   = 0;
   int mismatched = 0;

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   assign outDataS[0] = 32'($signed(outData0));
   assign outDataS[1] = 32'($signed(outData1));
   assign outDataS[2] = 32'($signed(outData2));

   mac_stream #(.W(8), .TAPS(4), .GUARD(4)) dut0 (
      .clk(clk), .clear(clear), .in_valid(inValid[0]), .in_ready(inReady[0]),
      .a(aIn[0]), .b(bIn[0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
      .out_data(outData0), .out_ovf(outOvf[0])
   );

   mac_stream #(.W(8), .TAPS(4), .GUARD(0)) dut1 (
      .clk(clk), .clear(clear), .in_valid(inValid[1]), .in_ready(inReady[1]),
      .a(aIn[1]), .b(bIn[1]), .out_valid(outValid[1]), .out_ready(outReady[1]),
      .out_data(outData1), .out_ovf(outOvf[1])
   );

   mac_stream #(.W(8), .TAPS(1), .GUARD(4)) dut2 (
      .clk(clk), .clear(clear), .in_valid(inValid[2]), .in_ready(inReady[2]),
      .a(aIn[2]), .b(bIn[2]), .out_valid(outValid[2]), .out_ready(outReady[2]),
      .out_data(outData2), .out_ovf(outOvf[2])
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Offer one pair to dut d and return right after the edge that accepts it.
   task automatic applyStimulus(input int d, input int av, input int bv);
      int tries;
      @(negedge clk);
      inValid[d] = 1'b1;
      aIn[d] = 8'(av);
      bIn[d] = 8'(bv);
      tries = 0;
      forever begin
         #1;
         if (inReady[d]) begin
            @(posedge clk);
            break;
         end
         tries++;
         if (tries > 100) begin
            checkOutput("in_ready timeout", 0, 1);
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic idle(input int d);
      @(negedge clk);
      inValid[d] = 1'b0;
   endtask

   task automatic expectResult(input int d, input int data, input bit ovf);
      expData[d].push_back(data);
      expOvf[d].push_back(ovf);
   endtask

   // Pops and compares whenever a DUT result is handed over on the coming edge.
   task automatic monitorLoop();
      int ed;
      bit eo;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            if (outValid[d] && outReady[d]) begin
               if (expData[d].size() == 0) begin
                  compared++;
                  mismatched++;
                  $display("[TB] FAIL unexpected result dut%0d: got %0d, expected none", d, outDataS[d]);
               end else begin
                  ed = expData[d].pop_front();
                  eo = expOvf[d].pop_front();
                  checkOutput($sformatf("dut%0d out_data", d), outDataS[d], ed);
                  checkOutput($sformatf("dut%0d out_ovf", d), int'(outOvf[d]), int'(eo));
               end
            end
         end
      end
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while ((expData[0].size() + expData[1].size() + expData[2].size()) != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      checkOutput("results outstanding", expData[0].size() + expData[1].size() + expData[2].size(), 0);
   endtask

   initial begin
      clear = 1'b1;
      for (int d = 0; d < 3; d++) begin
         inValid[d]  = 1'b1;
         aIn[d]      = 8'd7;
         bIn[d]      = 8'd7;
         outReady[d] = 1'b1;
      end
      fork
         monitorLoop();
      join_none

      // Reset held two cycles with in_valid high: nothing may be produced.
      repeat (2) @(posedge clk);
      @(negedge clk);
      clear = 1'b0;
      for (int d = 0; d < 3; d++) inValid[d] = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         checkOutput($sformatf("reset dut%0d out_valid", d), int'(outValid[d]), 0);
         checkOutput($sformatf("reset dut%0d out_data", d), outDataS[d], 0);
         checkOutput($sformatf("reset dut%0d out_ovf", d), int'(outOvf[d]), 0);
         checkOutput($sformatf("reset dut%0d in_ready", d), int'(inReady[d]), 1);
      end

      // Basic frame: 1+2+3+4.
      expectResult(0, 10, 1'b0);
      for (int i = 1; i <= 4; i++) applyStimulus(0, i, 1);
      idle(0);

      // (-128)*(-128) = 16384, four of them with bubbles = 65536; fits in 20 bits.
      expectResult(0, 65536, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, -128, -128);
         idle(0);
      end

      // -6 - 5 + 7 + 0 = -4.
      expectResult(0, -4, 1'b0);
      applyStimulus(0, -3, 2);
      applyStimulus(0, 5, -1);
      applyStimulus(0, 7, 1);
      applyStimulus(0, 0, 9);
      idle(0);

      // 16-bit accumulator: 16384*4 crosses +32767 on the second add.
`ifdef MAC_STREAM_SAT_EN
      expectResult(1, 32767, 1'b1);
`else
      expectResult(1, 0, 1'b1);
`endif
      for (int i = 0; i < 4; i++) applyStimulus(1, -128, -128);
      expectResult(1, 4, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1);
      idle(1);

      // TAPS=1: every pair is its own frame.
      expectResult(2, -16256, 1'b0);
      expectResult(2, -12, 1'b0);
      expectResult(2, 16384, 1'b0);
      applyStimulus(2, -128, 127);
      applyStimulus(2, 3, -4);
      applyStimulus(2, -128, -128);
      idle(2);
      waitDrain();

      // Backpressure: two back-to-back frames, first result held for six cycles.
      expectResult(0, 10, 1'b0);
      expectResult(0, 26, 1'b0);
      fork
         begin
            for (int i = 1; i <= 8; i++) applyStimulus(0, i, 1);
            idle(0);
         end
         begin
            int waitCnt;
            waitCnt = 0;
            forever begin
               @(posedge clk);
               #1;
               if (outValid[0] || waitCnt > 50) break;
               waitCnt++;
            end
            if (!outValid[0]) begin
               checkOutput("backpressure out_valid timeout", 0, 1);
            end else begin
               outReady[0] = 1'b0;
               repeat (6) begin
                  @(negedge clk);
                  checkOutput("held out_data", outDataS[0], 10);
                  checkOutput("held out_valid", int'(outValid[0]), 1);
                  checkOutput("held in_ready", int'(inReady[0]), 0);
               end
               @(posedge clk);
               #1;
               outReady[0] = 1'b1;
            end
         end
      join
      waitDrain();

      // Clear in the middle of a frame: the two 81s must leave no trace.
      applyStimulus(0, 9, 9);
      applyStimulus(0, 9, 9);
      @(negedge clk);
      inValid[0] = 1'b0;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      expectResult(0, 10, 1'b0);
      for (int i = 1; i <= 4; i++) applyStimulus(0, i, 1);
      idle(0);
      waitDrain();

      repeat (10) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
